// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I datapath: sequences fetch/decode/exec/mem/wb.
// Define ILLEGAL_TRAP_EN to trap on unknown opcodes; otherwise they retire as NOPs.
module rv32i_multicycle_ctrl #(
  parameter int unsigned RETIRE_W    = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                run_i,
  input  logic [6:0]          opcode_i,
  input  logic                branch_taken_i,
  input  logic                mem_ready_i,
  output logic                ir_write_o,
  output logic                pc_write_o,
  output logic [1:0]          pc_sel_o,
  output logic [1:0]          alu_src_a_o,
  output logic                alu_src_b_o,
  output logic                reg_write_o,
  output logic [1:0]          wb_sel_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [2:0]          state_o,
  output logic                mem_err_o,
  output logic                illegal_o,
  output logic [RETIRE_W-1:0] retired_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    mem_cnt_q, mem_cnt_d;
  logic [RETIRE_W-1:0] retired_q;
  logic                mem_err_q;
  logic                instr_end, err_set, known_op;
  logic [1:0]          op_a;
  logic                op_b;

  always_comb begin
    known_op = 1'b0;
    op_a     = 2'd0;
    op_b     = 1'b0;
    case (opcode_i)
      OP_R, OP_BR, OP_JAL:                begin known_op = 1'b1; end
      OP_IMM, OP_LOAD, OP_STORE, OP_JALR: begin known_op = 1'b1; op_b = 1'b1; end
      OP_LUI:   begin known_op = 1'b1; op_a = 2'd2; op_b = 1'b1; end
      OP_AUIPC: begin known_op = 1'b1; op_a = 2'd1; op_b = 1'b1; end
      default: ;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, ill_set;
`endif

  always_comb begin
    state_d     = state_q;
    mem_cnt_d   = '0;
    instr_end   = 1'b0;
    err_set     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    ill_set     = 1'b0;
`endif
    ir_write_o  = 1'b0;
    pc_write_o  = 1'b0;
    pc_sel_o    = 2'd0;
    alu_src_a_o = 2'd0;
    alu_src_b_o = 1'b0;
    reg_write_o = 1'b0;
    wb_sel_o    = 2'd0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    case (state_q)
      S_IDLE:  if (run_i) state_d = S_FETCH;
      S_FETCH: begin
        ir_write_o = 1'b1;
        pc_write_o = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        if (known_op) begin
          state_d = S_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_TRAP;
          ill_set = 1'b1;
`else
          instr_end = 1'b1;
`endif
        end
      end
      S_EXEC: begin
        alu_src_a_o = op_a;
        alu_src_b_o = op_b;
        case (opcode_i)
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_BR: begin
            pc_write_o = branch_taken_i;
            pc_sel_o   = 2'd1;
            instr_end  = 1'b1;
          end
          OP_JAL:  begin pc_write_o = 1'b1; pc_sel_o = 2'd1; state_d = S_WB; end
          OP_JALR: begin pc_write_o = 1'b1; pc_sel_o = 2'd2; state_d = S_WB; end
          OP_R, OP_IMM, OP_LUI, OP_AUIPC: state_d = S_WB;
          default: instr_end = 1'b1;
        endcase
      end
      S_MEM: begin
        // ALU selects held so an unregistered address stays stable for the whole access
        alu_src_a_o = op_a;
        alu_src_b_o = op_b;
        mem_req_o   = 1'b1;
        mem_we_o    = (opcode_i == OP_STORE);
        if (mem_ready_i) begin
          if (opcode_i == OP_LOAD) state_d = S_WB;
          else                     instr_end = 1'b1;
        end else if (MEM_TIMEOUT != 0 && mem_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          err_set   = 1'b1;
          instr_end = 1'b1;
        end else begin
          mem_cnt_d = mem_cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        alu_src_a_o = op_a;
        alu_src_b_o = op_b;
        reg_write_o = 1'b1;
        if (opcode_i == OP_LOAD)                           wb_sel_o = 2'd1;
        else if (opcode_i == OP_JAL || opcode_i == OP_JALR) wb_sel_o = 2'd2;
        instr_end   = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
    if (instr_end) state_d = run_i ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      mem_cnt_q <= '0;
      retired_q <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_cnt_q <= mem_cnt_d;
      retired_q <= retired_q + RETIRE_W'(instr_end);
      mem_err_q <= mem_err_q | err_set;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) illegal_q <= 1'b0;
    else         illegal_q <= illegal_q | ill_set;
  end
  assign illegal_o = illegal_q;
`else
  assign illegal_o = 1'b0;
`endif

  assign state_o   = state_q;
  assign retired_o = retired_q;
  assign mem_err_o = mem_err_q;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Self-checking bench for rv32i_multicycle_ctrl: directed scenarios plus random
// instruction streams checked against a per-instruction behavioural model.
module tb_rv32i_multicycle_ctrl;
  localparam int unsigned RW  = 32;
  localparam int          TMO = 16;

  logic          clk, rst_n, run, taken, ready;
  logic [6:0]    opcode;
  logic          ir_write, pc_write, alu_b, reg_write, mem_req, mem_we, mem_err, illegal;
  logic [1:0]    pc_sel, alu_a, wb_sel;
  logic [2:0]    state;
  logic [RW-1:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  rv32i_multicycle_ctrl #(.RETIRE_W(RW), .MEM_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .run_i(run), .opcode_i(opcode),
    .branch_taken_i(taken), .mem_ready_i(ready),
    .ir_write_o(ir_write), .pc_write_o(pc_write), .pc_sel_o(pc_sel),
    .alu_src_a_o(alu_a), .alu_src_b_o(alu_b), .reg_write_o(reg_write),
    .wb_sel_o(wb_sel), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .state_o(state), .mem_err_o(mem_err), .illegal_o(illegal), .retired_o(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         lat;
    int         memc;
    int         we;
    int         rw;
    logic [1:0] wbs;
    int         pcw_exec;
    logic [1:0] pcs;
    logic       chk_alu;
    logic [1:0] a;
    logic       b;
    logic       tmo;
  } exp_t;

  function automatic logic is_known(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
  endfunction

  // Expected per-instruction totals; n = MEM cycle on which ready arrives (0 = never)
  function automatic exp_t model(input logic [6:0] op, input logic tk, input int n);
    exp_t e;
    bit   ok;
    e  = '{default: 0};
    ok = (n >= 1 && n <= TMO);
    case (op)
      7'h33: begin e.lat = 4; e.rw = 1; e.chk_alu = 1; e.a = 2'd0; e.b = 1'b0; end
      7'h13: begin e.lat = 4; e.rw = 1; e.chk_alu = 1; e.a = 2'd0; e.b = 1'b1; end
      7'h37: begin e.lat = 4; e.rw = 1; e.chk_alu = 1; e.a = 2'd2; e.b = 1'b1; end
      7'h17: begin e.lat = 4; e.rw = 1; e.chk_alu = 1; e.a = 2'd1; e.b = 1'b1; end
      7'h6F: begin e.lat = 4; e.rw = 1; e.wbs = 2'd2; e.pcw_exec = 1; e.pcs = 2'd1; end
      7'h67: begin
        e.lat = 4; e.rw = 1; e.wbs = 2'd2; e.pcw_exec = 1; e.pcs = 2'd2;
        e.chk_alu = 1; e.a = 2'd0; e.b = 1'b1;
      end
      7'h63: begin e.lat = 3; e.pcw_exec = tk ? 1 : 0; e.pcs = 2'd1; e.chk_alu = 1; end
      7'h03: begin
        e.chk_alu = 1; e.b = 1'b1;
        if (ok) begin e.lat = 4 + n; e.memc = n; e.rw = 1; e.wbs = 2'd1; end
        else begin e.lat = 3 + TMO; e.memc = TMO; e.tmo = 1'b1; end
      end
      7'h23: begin
        e.chk_alu = 1; e.b = 1'b1;
        if (ok) begin e.lat = 3 + n; e.memc = n; end
        else begin e.lat = 3 + TMO; e.memc = TMO; e.tmo = 1'b1; end
        e.we = e.memc;
      end
      default: e.lat = 2;
    endcase
    return e;
  endfunction

  task automatic goto_fetch();
    int k = 0;
    if (state !== 3'd1) begin
      run = 1'b1;
      while (state !== 3'd1 && k < 4) begin @(negedge clk); k++; end
      n_checks++;
      if (state !== 3'd1) begin
        n_fail++; $display("FAIL goto_fetch: state=%0d required 1", state);
      end
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input logic tk, input int n, input bit drop_run);
    exp_t          e;
    int            cyc = 0, memc = 0, mem_cyc = 0, we = 0, rw = 0, pcw = 0, pcw_exec = 0;
    int            irw = 0, ovl = 0;
    logic [1:0]    wbs = 2'd3, pcs = 2'd3, a = 2'd3;
    logic          b = 1'b0, last_run = 1'b0;
    logic [RW-1:0] ret0;
    logic          err0;
    goto_fetch();
    e = model(op, tk, n);
    ret0 = retired; err0 = mem_err;
    opcode = op; taken = tk;
    do begin
      cyc++;
      if (ir_write) irw++;
      if (pc_write) begin
        pcw++;
        if (state === 3'd3) begin pcw_exec++; pcs = pc_sel; end
      end
      if (reg_write) begin rw++; wbs = wb_sel; end
      if (mem_req) begin memc++; if (mem_we) we++; end
      if (mem_req && (pc_write || reg_write)) ovl++;
      if (state === 3'd3) begin a = alu_a; b = alu_b; end
      if (state === 3'd4) mem_cyc++;
      ready    = (state === 3'd4) ? (mem_cyc == n) : 1'($urandom_range(0, 1));
      last_run = drop_run ? (cyc == 1) : ($urandom_range(0, 3) != 0);
      run      = last_run;
      @(negedge clk);
    end while (state !== 3'd1 && state !== 3'd0 && cyc < 60);
    ready = 1'b0;
    n_checks++; if (cyc != e.lat) begin n_fail++; $display("FAIL latency op=%h: %0d cycles, required %0d", op, cyc, e.lat); end
    n_checks++; if (state !== (last_run ? 3'd1 : 3'd0)) begin n_fail++; $display("FAIL end_state op=%h: %0d, required %0d", op, state, last_run ? 1 : 0); end
    n_checks++; if (retired !== ret0 + 1) begin n_fail++; $display("FAIL retired op=%h: %0d, required %0d", op, retired, ret0 + 1); end
    n_checks++; if (mem_err !== (err0 | e.tmo)) begin n_fail++; $display("FAIL mem_err op=%h: %b, required %b", op, mem_err, err0 | e.tmo); end
    n_checks++; if (memc != e.memc) begin n_fail++; $display("FAIL mem_req_cycles op=%h: %0d, required %0d", op, memc, e.memc); end
    n_checks++; if (we != e.we) begin n_fail++; $display("FAIL mem_we_cycles op=%h: %0d, required %0d", op, we, e.we); end
    n_checks++; if (rw != e.rw) begin n_fail++; $display("FAIL reg_write_cycles op=%h: %0d, required %0d", op, rw, e.rw); end
    if (e.rw != 0) begin
      n_checks++; if (wbs !== e.wbs) begin n_fail++; $display("FAIL wb_sel op=%h: %0d, required %0d", op, wbs, e.wbs); end
    end
    n_checks++; if (pcw != 1 + e.pcw_exec) begin n_fail++; $display("FAIL pc_write_cycles op=%h: %0d, required %0d", op, pcw, 1 + e.pcw_exec); end
    n_checks++; if (pcw_exec != e.pcw_exec) begin n_fail++; $display("FAIL exec_pc_write op=%h: %0d, required %0d", op, pcw_exec, e.pcw_exec); end
    if (e.pcw_exec != 0) begin
      n_checks++; if (pcs !== e.pcs) begin n_fail++; $display("FAIL pc_sel op=%h: %0d, required %0d", op, pcs, e.pcs); end
    end
    n_checks++; if (irw != 1) begin n_fail++; $display("FAIL ir_write_cycles op=%h: %0d, required 1", op, irw); end
    n_checks++; if (ovl != 0) begin n_fail++; $display("FAIL write_with_mem_req op=%h: %0d cycles, required 0", op, ovl); end
    if (e.chk_alu) begin
      n_checks++; if ({a, b} !== {e.a, e.b}) begin n_fail++; $display("FAIL alu_src op=%h: a=%0d b=%0d, required a=%0d b=%0d", op, a, b, e.a, e.b); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: %0d, required 0", state); end
    n_checks++;
    if ({ir_write, pc_write, pc_sel, alu_a, alu_b, reg_write, wb_sel, mem_req, mem_we} !== 13'd0) begin
      n_fail++; $display("FAIL reset_controls: %b, required all 0",
        {ir_write, pc_write, pc_sel, alu_a, alu_b, reg_write, wb_sel, mem_req, mem_we});
    end
    n_checks++; if ({retired, mem_err, illegal} !== '0) begin n_fail++; $display("FAIL reset_status: retired=%0d err=%b ill=%b, required 0", retired, mem_err, illegal); end
    run = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL idle_hold: %0d, required 0", state); end
  endtask

  task automatic test_alu_trace();
    logic [2:0] exp_st [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    opcode = 7'h33; run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (state !== exp_st[i]) begin n_fail++; $display("FAIL trace_state[%0d]: %0d, required %0d", i, state, exp_st[i]); end
      n_checks++; if (reg_write !== (exp_st[i] == 3'd5)) begin n_fail++; $display("FAIL trace_reg_write[%0d]: %b", i, reg_write); end
      if (i == 3) begin
        n_checks++; if (wb_sel !== 2'd0) begin n_fail++; $display("FAIL trace_wb_sel: %0d, required 0", wb_sel); end
      end
    end
    n_checks++; if (retired !== 1) begin n_fail++; $display("FAIL trace_retired: %0d, required 1", retired); end
  endtask

  task automatic test_load();        run_instr(7'h03, 1'b0, 3, 1'b0); endtask
  task automatic test_branch();
    run_instr(7'h63, 1'b1, 0, 1'b0);
    run_instr(7'h63, 1'b0, 0, 1'b0);
  endtask
  task automatic test_store_timeout(); run_instr(7'h23, 1'b0, 0, 1'b0); endtask
  task automatic test_run_drop_jal();  run_instr(7'h6F, 1'b0, 0, 1'b1); endtask

  task automatic test_illegal();
`ifdef ILLEGAL_TRAP_EN
    logic [RW-1:0] ret0;
    goto_fetch();
    opcode = 7'h7F; run = 1'b1; ret0 = retired;
    repeat (3) @(negedge clk);
    n_checks++; if (state !== 3'd6) begin n_fail++; $display("FAIL trap_state: %0d, required 6", state); end
    n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL trap_illegal: %b, required 1", illegal); end
    run = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (state !== 3'd6 || illegal !== 1'b1) begin n_fail++; $display("FAIL trap_stuck: state=%0d ill=%b", state, illegal); end
    n_checks++; if (retired !== ret0) begin n_fail++; $display("FAIL trap_retired: %0d, required %0d", retired, ret0); end
    n_checks++; if ({reg_write, pc_write, mem_req} !== 3'b000) begin n_fail++; $display("FAIL trap_writes: %b, required 000", {reg_write, pc_write, mem_req}); end
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL trap_clear: %b, required 0", illegal); end
`else
    run_instr(7'h7F, 1'b0, 0, 1'b0);
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_tied: %b, required 0", illegal); end
`endif
  endtask

  task automatic test_random();
    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
    logic [6:0] op;
    int         k;
    for (int i = 0; i < 60; i++) begin
`ifdef ILLEGAL_TRAP_EN
      k = $urandom_range(0, 8);
`else
      k = $urandom_range(0, 9);
`endif
      if (k == 9) begin
        do op = 7'($urandom); while (is_known(op));
      end else begin
        op = ops[k];
      end
      run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, TMO + 2), 1'b0);
    end
  endtask

  task automatic test_reset_mid_mem();
    int k = 0;
    goto_fetch();
    opcode = 7'h03; ready = 1'b0; run = 1'b1;
    while (state !== 3'd4 && k < 10) begin @(negedge clk); k++; end
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL pre_reset_mem_req: %b, required 1", mem_req); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL abort_state: %0d, required 0", state); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL abort_mem_req: %b, required 0", mem_req); end
    n_checks++; if (retired !== 0 || mem_err !== 1'b0) begin n_fail++; $display("FAIL abort_status: retired=%0d err=%b, required 0", retired, mem_err); end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; taken = 1'b0; ready = 1'b0; opcode = 7'h00;
    test_reset();
    test_alu_trace();
    test_load();
    test_branch();
    test_store_timeout();
    test_run_drop_jal();
    test_illegal();
    test_random();
    test_reset_mid_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
